// File: rtl/io_terminal.sv
// Device side of the FGI/INPR and FGO/OUTR programmed-I/O handshake.
// Define IO_TERM_FIFO_EN to put an IN_DEPTH-entry FIFO ahead of inpr.
module io_terminal #(
   parameter int OUT_DELAY = 4,
   parameter int IN_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] inpr,
   output logic       fgi,
   input  logic       fgi_clr,
   input  logic [7:0] outr,
   output logic       fgo,
   input  logic       fgo_clr,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       err
);

   typedef enum logic [1:0] {
      O_IDLE,
      O_SEND,
      O_BUSY
   } ostate_e;

   localparam logic [7:0] CNT_INIT =
      (OUT_DELAY == 0) ? 8'd0 : 8'(OUT_DELAY - 1);

   ostate_e    state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] out_data_q, out_data_d;
   logic [7:0] inpr_q, inpr_d;
   logic       fgi_q, fgi_d;
   logic       err_q, err_d;
   logic       load;
   logic [7:0] load_data;

`ifdef IO_TERM_FIFO_EN
   localparam int AW = $clog2(IN_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [7:0] mem_q [IN_DEPTH];
   logic [7:0] mem_d [IN_DEPTH];
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic       full_q, full_d;
   logic       empty, push;

   assign empty     = (wr_q == rd_q);
   assign push      = in_valid & ~full_q;
   assign load      = ~fgi_q & ~empty;
   assign load_data = mem_q[rd_q[AW-1:0]];
   assign in_ready  = ~full_q;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push) begin
         mem_d[wr_q[AW-1:0]] = in_data;
         wr_d = wr_q + PTR_ONE;
      end
      if (load) rd_d = rd_q + PTR_ONE;
      // same index, different wrap bit: full
      full_d = (wr_d[AW-1:0] == rd_d[AW-1:0]) &&
               (wr_d[AW] != rd_d[AW]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         full_q <= 1'b0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         full_q <= full_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
`else
   logic [31:0] unused_depth;

   assign unused_depth = 32'(IN_DEPTH);
   assign in_ready     = ~fgi_q;
   assign load         = in_valid & ~fgi_q;
   assign load_data    = in_data;
`endif

   always_comb begin
      inpr_d     = inpr_q;
      fgi_d      = fgi_q;
      err_d      = err_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      out_data_d = out_data_q;
      if (load) begin
         inpr_d = load_data;
         fgi_d  = 1'b1;
      end
      if (fgi_clr) begin
         if (fgi_q) fgi_d = 1'b0;
         else       err_d = 1'b1;
      end
      if (fgo_clr && state_q != O_IDLE) err_d = 1'b1;
      unique case (state_q)
         O_IDLE: begin
            if (fgo_clr) begin
               out_data_d = outr;
               state_d    = O_SEND;
            end
         end
         O_SEND: begin
            if (out_ready) begin
               if (OUT_DELAY == 0) begin
                  state_d = O_IDLE;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = O_BUSY;
               end
            end
         end
         O_BUSY: begin
            if (cnt_q == 8'd0) state_d = O_IDLE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         default: state_d = O_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= O_IDLE;
         cnt_q      <= 8'd0;
         out_data_q <= 8'd0;
         inpr_q     <= 8'd0;
         fgi_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         out_data_q <= out_data_d;
         inpr_q     <= inpr_d;
         fgi_q      <= fgi_d;
         err_q      <= err_d;
      end
   end

   assign inpr      = inpr_q;
   assign fgi       = fgi_q;
   assign err       = err_q;
   assign out_data  = out_data_q;
   assign fgo       = (state_q == O_IDLE);
   assign out_valid = (state_q == O_SEND);

endmodule

// File: doc/io_terminal.md
# io_terminal

Device-side peripheral for the processor's programmed-I/O port: the other end of the FGI/INPR and FGO/OUTR handshake. A host byte stream is accepted, presented on `inpr`, and flagged with `fgi` until the CPU's INP consumes it. A byte written by the CPU's OUT is captured from `outr` and driven onto a byte stream. `fgo` is then held low for a programmable device-busy time. The block sits beside `microProcessor`, with its flags and data wired to the CPU's FGI/FGO/INPR/OUTR.

## Interface
Parameters:
- `OUT_DELAY`, default 4: device busy cycles after an output byte is delivered; legal range 0–255.
- `IN_DEPTH`, default 4: input FIFO depth; a power of two, 2–16; used only with `IO_TERM_FIFO_EN`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous reset, active-high.
- `in_data`  in  8  host input byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block accepts a byte; the transfer happens on the edge where `in_valid & in_ready`.
- `inpr`  out  8  input register to the CPU.
- `fgi`  out  1  input flag; 1 means `inpr` holds an unread byte.
- `fgi_clr`  in  1  one-cycle pulse from the CPU's INP.
- `outr`  in  8  CPU output register; sampled when `fgo_clr` is high.
- `fgo`  out  1  output flag; 1 means the device is ready for a byte.
- `fgo_clr`  in  1  one-cycle pulse from the CPU's OUT.
- `out_data`  out  8  output byte to the host.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  host accepts `out_data`.
- `err`  out  1  sticky protocol-violation flag.

## Operation
Reset values (on the edge where `rst=1`):
- Registers: `inpr=0`, `fgi=0`, `fgo=1`, `out_data=0`, `out_valid=0`, `err=0`.
- FIFO empty; output FSM in O_IDLE.
- `rst` overrides every in-flight transfer. A byte pending in the FIFO, in `inpr` or on `out_data` is discarded.

Input path:
- `fgi_clr` with `fgi=1` clears `fgi` on that edge.
- `fgi_clr` with `fgi=0` is ignored and sets `err`.
- `inpr` loads only on an edge where `fgi=0` at the start of the cycle. As a result, `fgi` is low for at least one full cycle between consecutive bytes.
- `inpr` holds its value after `fgi` clears.

Output FSM:
- O_IDLE: `fgo=1`, `out_valid=0`.
  - `fgo_clr` captures `outr` into `out_data`, sets `fgo=0` and `out_valid=1`, and moves to O_SEND.
- O_SEND: `out_valid=1`, `out_data` stable.
  - On `out_ready`, clear `out_valid`.
  - If `OUT_DELAY=0`, set `fgo=1` and go to O_IDLE.
  - Otherwise load `cnt=OUT_DELAY-1` and go to O_BUSY.
- O_BUSY: if `cnt==0`, set `fgo=1` and go to O_IDLE; otherwise decrement `cnt`.
- `fgo_clr` in O_SEND or O_BUSY (that is, while `fgo=0`) is ignored: `outr` is not captured and `err` is set.
- `err` clears only on `rst`.
- The input and output paths are independent. Simultaneous events on both paths are all honoured in the same cycle.

## Timing
- Direct mode: `in_ready = ~fgi` (combinational from the register). A handshake at edge N gives `inpr=in_data` and `fgi=1` after edge N.
- FIFO mode: a byte accepted into an empty FIFO with `fgi=0` at edge N is popped at edge N+1. `fgi=1` after edge N+1.
- Output latency: `fgo_clr` at edge N gives `out_valid=1` after edge N.
- Output handshake: for a handshake at edge M, `fgo=1` after edge M+`OUT_DELAY` (after edge M when `OUT_DELAY=0`).
- `out_valid`, once high, stays high with `out_data` unchanged until the handshake. Hosts may hold `out_ready` high permanently.

## Configuration
`IO_TERM_FIFO_EN` selects the input buffering.

Defined: an `IN_DEPTH`-entry FIFO sits between the host stream and `inpr`.
- `in_ready = ~full`, where `full` is the registered flag.
- Push and pop may occur on the same edge.
- When full, `in_ready` stays 0 even on a cycle that pops.
- Pop whenever `fgi=0` and the FIFO is not empty.
- Read and write pointers wrap modulo `IN_DEPTH`, with one extra wrap bit used to distinguish full from empty.

Undefined: no FIFO; direct mode as described in Timing.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid=1` and `fgo_clr=1` → `fgi=0`, `fgo=1`, `out_valid=0`, `err=0`, `inpr=0`; nothing captured.
- Input handshake: send 0x53, then `fgi_clr` 3 cycles later → `inpr=0x53` and `fgi=1` at the stated latency; `fgi=0` after the clear. Then send 0xE9 → `inpr=0xE9` with at least one cycle of `fgi=0` in between.
- FIFO mode: push 0x01..0x05 back-to-back with no `fgi_clr` → `in_ready` drops after 4 accepted (5 when counting the byte already in `inpr`). Clearing `fgi` repeatedly → `inpr` yields 0x01..0x05 in order.
- Output, `OUT_DELAY=4`: `fgo_clr` with `outr=0x3C`, `out_ready` asserted 2 cycles later → `out_data=0x3C`; `fgo` returns to 1 exactly 4 edges after the handshake.
- Backpressure: hold `out_ready=0` for 10 cycles → `out_valid` and `out_data` stay stable and `fgo` stays 0 throughout.
- Protocol errors: `fgo_clr` during O_BUSY with `outr=0xAA` → `out_data` unchanged and `err=1`. Separately, `fgi_clr` with `fgi=0` → `err=1`. In both cases `err` holds until `rst`.
